// File: rtl/waveform_formatter_pkg.sv
// -----------------------------------------------------------------------------
// waveform_formatter_pkg
// Shared constants and types for the waveform fragment reassembler:
//   - WFRM_CMD_DEFAULT : expected header word 0 ("WWDA")
//   - HDR_* offsets    : position of each header word inside a fragment
//   - HDR_WORDS        : number of header words preceding fragment data
//   - wfrm_state_e     : reassembly FSM states; the header states share their
//                        encoding with the header word offset they consume
//   - is_header()      : true while the FSM is consuming header words
// -----------------------------------------------------------------------------
package waveform_formatter_pkg;

    localparam logic [31:0] WFRM_CMD_DEFAULT = 32'h57574441;

    localparam logic [2:0] HDR_CMD  = 3'd0;
    localparam logic [2:0] HDR_ID   = 3'd1;
    localparam logic [2:0] HDR_IND  = 3'd2;
    localparam logic [2:0] HDR_LEN  = 3'd3;
    localparam logic [2:0] HDR_RSVD = 3'd4;
    localparam int         HDR_WORDS = 5;

    typedef enum logic [2:0] {
        H_CMD  = HDR_CMD,
        H_ID   = HDR_ID,
        H_IND  = HDR_IND,
        H_LEN  = HDR_LEN,
        H_RSVD = HDR_RSVD,
        DATA   = 3'd5,
        DROP   = 3'd6
    } wfrm_state_e;

    function automatic logic is_header(input wfrm_state_e s);
        return (s == H_CMD) || (s == H_ID) || (s == H_IND) ||
               (s == H_LEN) || (s == H_RSVD);
    endfunction

endpackage

// File: rtl/waveform_formatter_axis_out_reg.sv
// -----------------------------------------------------------------------------
// axis_out_reg
// One-entry AXI-Stream output register. A word is loaded when in_valid and
// in_ready; it is held (valid and payload stable) until out_ready takes it.
// Full throughput: a new word can be loaded in the same cycle the held word
// leaves.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     upstream handshake (in_ready = ~valid | out_ready)
//   in_payload            word to register
//   out_valid/out_ready   downstream handshake
//   out_payload           registered word (cleared by reset)
// -----------------------------------------------------------------------------
module axis_out_reg
    import waveform_formatter_pkg::*;
#(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload
);

    logic                 valid_q, valid_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;

    assign in_ready    = ~valid_q | out_ready;
    assign out_valid   = valid_q;
    assign out_payload = payload_q;

    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        if (in_valid && in_ready) begin
            valid_d   = 1'b1;
            payload_d = in_payload;
        end else if (out_ready) begin
            valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

endmodule

// File: rtl/waveform_formatter.sv
// -----------------------------------------------------------------------------
// waveform_formatter
// Reassembles fragmented waveform packets into one contiguous AXI-Stream
// waveform. Each fragment = 5 header words (CMD, ID, IND, LEN, reserved) plus
// data words. Headers are checked and stripped, data words are forwarded with
// their keep/dest/id/user sidebands, and tlast marks the LEN-th data word of
// the whole waveform.
// Ports:
//   axi_tclk, axi_treset   clock, asynchronous active-high reset
//   wfrm_axis_*            fragment input stream (tready is an output)
//   tdata..tuser, tvalid   reassembled output stream, tready input
// Optional feature (macro WAVEFORM_FORMATTER_ORDER_CHECK_EN):
//   continuation fragments (IND != 0) are accepted only if IND matches the
//   expected fragment index and ID matches the ID of the current waveform.
//   Without the macro every fragment with a correct CMD is forwarded.
// -----------------------------------------------------------------------------
module waveform_formatter
    import waveform_formatter_pkg::*;
#(
    parameter logic [31:0] WFRM_CMD = WFRM_CMD_DEFAULT,
    parameter int          DEST_W   = 1,
    parameter int          ID_W     = 1,
    parameter int          USER_W   = 1
) (
    input  logic              axi_tclk,
    input  logic              axi_treset,
    input  logic [31:0]       wfrm_axis_tdata,
    input  logic              wfrm_axis_tvalid,
    input  logic              wfrm_axis_tlast,
    input  logic [3:0]        wfrm_axis_tkeep,
    input  logic [DEST_W-1:0] wfrm_axis_tdest,
    input  logic [ID_W-1:0]   wfrm_axis_tid,
    input  logic [USER_W-1:0] wfrm_axis_tuser,
    output logic              wfrm_axis_tready,
    output logic [31:0]       tdata,
    output logic              tvalid,
    output logic              tlast,
    output logic [3:0]        tkeep,
    output logic [DEST_W-1:0] tdest,
    output logic [ID_W-1:0]   tid,
    output logic [USER_W-1:0] tuser,
    input  logic              tready
);

    localparam int PAYLOAD_W = 1 + 4 + DEST_W + ID_W + USER_W + 32;

    wfrm_state_e state_q, state_d;
    logic        active_q, active_d;      // holds input ready low while in reset
    logic [31:0] wave_len_q, wave_len_d;  // LEN of the waveform being built
    logic [31:0] out_cnt_q, out_cnt_d;    // data words output for this waveform
    logic        new_wave_q, new_wave_d;  // current fragment has IND == 0
    logic        frag_bad_q, frag_bad_d;  // current fragment failed order check

`ifdef WAVEFORM_FORMATTER_ORDER_CHECK_EN
    logic [31:0] exp_ind_q, exp_ind_d;    // next fragment index we expect
    logic [31:0] frag_id_q, frag_id_d;    // ID field of the current fragment
    logic [31:0] wave_id_q, wave_id_d;    // ID of the waveform being built
`endif

    logic                 in_accept;
    logic                 push;
    logic                 last_word;
    logic                 reg_in_ready;
    logic [PAYLOAD_W-1:0] push_payload;
    logic [PAYLOAD_W-1:0] out_payload;

    // Header and drop states always sink words; in DATA the input is
    // throttled by the output register.
    assign wfrm_axis_tready = active_q &
                              ((state_q != DATA) | reg_in_ready);
    assign in_accept = wfrm_axis_tvalid & wfrm_axis_tready;
    assign push      = in_accept & (state_q == DATA);
    assign last_word = ((out_cnt_q + 32'd1) == wave_len_q);

    assign push_payload = {last_word, wfrm_axis_tkeep, wfrm_axis_tdest,
                           wfrm_axis_tid, wfrm_axis_tuser, wfrm_axis_tdata};
    assign {tlast, tkeep, tdest, tid, tuser, tdata} = out_payload;

    always_comb begin
        state_d    = state_q;
        active_d   = 1'b1;
        wave_len_d = wave_len_q;
        out_cnt_d  = out_cnt_q;
        new_wave_d = new_wave_q;
        frag_bad_d = frag_bad_q;
`ifdef WAVEFORM_FORMATTER_ORDER_CHECK_EN
        exp_ind_d  = exp_ind_q;
        frag_id_d  = frag_id_q;
        wave_id_d  = wave_id_q;
`endif
        if (in_accept) begin
            case (state_q)
                H_CMD: begin
                    new_wave_d = 1'b0;
                    frag_bad_d = 1'b0;
                    if (wfrm_axis_tlast) begin
                        state_d = H_CMD;
                    end else if (wfrm_axis_tdata != WFRM_CMD) begin
                        state_d = DROP;
                    end else begin
                        state_d = H_ID;
                    end
                end
                H_ID: begin
`ifdef WAVEFORM_FORMATTER_ORDER_CHECK_EN
                    frag_id_d = wfrm_axis_tdata;
`endif
                    state_d = wfrm_axis_tlast ? H_CMD : H_IND;
                end
                H_IND: begin
                    new_wave_d = (wfrm_axis_tdata == 32'd0);
`ifdef WAVEFORM_FORMATTER_ORDER_CHECK_EN
                    frag_bad_d = (wfrm_axis_tdata != 32'd0) &&
                                 ((wfrm_axis_tdata != exp_ind_q) ||
                                  (frag_id_q != wave_id_q));
`endif
                    state_d = wfrm_axis_tlast ? H_CMD : H_LEN;
                end
                H_LEN: begin
                    // A fragment with IND == 0 (re)starts the waveform.
                    if (new_wave_q) begin
                        wave_len_d = wfrm_axis_tdata;
                        out_cnt_d  = 32'd0;
`ifdef WAVEFORM_FORMATTER_ORDER_CHECK_EN
                        wave_id_d  = frag_id_q;
                        exp_ind_d  = 32'd0;
`endif
                    end
                    state_d = wfrm_axis_tlast ? H_CMD : H_RSVD;
                end
                H_RSVD: begin
                    // Nothing to forward if the waveform is empty or already
                    // complete (a stray continuation fragment).
                    if (wfrm_axis_tlast) begin
                        state_d = H_CMD;
                    end else if (frag_bad_q || (wave_len_q == 32'd0) ||
                                 (out_cnt_q >= wave_len_q)) begin
                        state_d = DROP;
                    end else begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    out_cnt_d = out_cnt_q + 32'd1;
                    if (last_word) begin
`ifdef WAVEFORM_FORMATTER_ORDER_CHECK_EN
                        exp_ind_d = 32'd0;
`endif
                        // If the final word also ends the fragment there is
                        // nothing left to drop.
                        state_d = wfrm_axis_tlast ? H_CMD : DROP;
                    end else if (wfrm_axis_tlast) begin
`ifdef WAVEFORM_FORMATTER_ORDER_CHECK_EN
                        exp_ind_d = exp_ind_q + 32'd1;
`endif
                        state_d = H_CMD;
                    end
                end
                DROP: begin
                    if (wfrm_axis_tlast) begin
                        state_d = H_CMD;
                    end
                end
                default: begin
                    state_d = H_CMD;
                end
            endcase
        end
    end

    always_ff @(posedge axi_tclk or posedge axi_treset) begin
        if (axi_treset) begin
            state_q    <= H_CMD;
            active_q   <= 1'b0;
            wave_len_q <= 32'd0;
            out_cnt_q  <= 32'd0;
            new_wave_q <= 1'b0;
            frag_bad_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            wave_len_q <= wave_len_d;
            out_cnt_q  <= out_cnt_d;
            new_wave_q <= new_wave_d;
            frag_bad_q <= frag_bad_d;
        end
    end

`ifdef WAVEFORM_FORMATTER_ORDER_CHECK_EN
    always_ff @(posedge axi_tclk or posedge axi_treset) begin
        if (axi_treset) begin
            exp_ind_q <= 32'd0;
            frag_id_q <= 32'd0;
            wave_id_q <= 32'd0;
        end else begin
            exp_ind_q <= exp_ind_d;
            frag_id_q <= frag_id_d;
            wave_id_q <= wave_id_d;
        end
    end
`endif

    axis_out_reg #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_out_reg (
        .clk         (axi_tclk),
        .rst         (axi_treset),
        .in_valid    (push),
        .in_ready    (reg_in_ready),
        .in_payload  (push_payload),
        .out_valid   (tvalid),
        .out_ready   (tready),
        .out_payload (out_payload)
    );

endmodule

// File: tb/tb_waveform_formatter.sv
module tb_waveform_formatter;
    import waveform_formatter_pkg::*;

    localparam logic [31:0] CMD = 32'h57574441;
`ifdef WAVEFORM_FORMATTER_ORDER_CHECK_EN
    localparam bit ORDER_CHK = 1'b1;
`else
    localparam bit ORDER_CHK = 1'b0;
`endif

    logic        axi_tclk = 1'b0;
    logic        axi_treset = 1'b1;
    logic [31:0] wfrm_axis_tdata = '0;
    logic        wfrm_axis_tvalid = 1'b0;
    logic        wfrm_axis_tlast = 1'b0;
    logic [3:0]  wfrm_axis_tkeep = '0;
    logic        wfrm_axis_tdest = 1'b0;
    logic        wfrm_axis_tid = 1'b0;
    logic        wfrm_axis_tuser = 1'b0;
    logic        wfrm_axis_tready;
    logic [31:0] tdata;
    logic        tvalid, tlast;
    logic [3:0]  tkeep;
    logic        tdest, tid, tuser;
    logic        tready = 1'b1;

    waveform_formatter #(
        .WFRM_CMD (CMD), .DEST_W (1), .ID_W (1), .USER_W (1)
    ) dut (
        .axi_tclk         (axi_tclk),
        .axi_treset       (axi_treset),
        .wfrm_axis_tdata  (wfrm_axis_tdata),
        .wfrm_axis_tvalid (wfrm_axis_tvalid),
        .wfrm_axis_tlast  (wfrm_axis_tlast),
        .wfrm_axis_tkeep  (wfrm_axis_tkeep),
        .wfrm_axis_tdest  (wfrm_axis_tdest),
        .wfrm_axis_tid    (wfrm_axis_tid),
        .wfrm_axis_tuser  (wfrm_axis_tuser),
        .wfrm_axis_tready (wfrm_axis_tready),
        .tdata            (tdata),
        .tvalid           (tvalid),
        .tlast            (tlast),
        .tkeep            (tkeep),
        .tdest            (tdest),
        .tid              (tid),
        .tuser            (tuser),
        .tready           (tready)
    );

    always #5 axi_tclk = ~axi_tclk;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [3:0]  keep;
        logic        dest;
        logic        id;
        logic        user;
    } beat_t;

    beat_t       in_q[$];
    logic [39:0] exp_q[$];
    logic [39:0] out_vec;
    assign out_vec = {tdata, tkeep, tdest, tid, tuser, tlast};

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int tready_mode = 0;   // 0: always 1, 1: toggle, 2: random
    bit rand_valid = 1'b0;
    bit prev_stall = 1'b0;
    logic [39:0] held_vec = '0;
    int xfer_cnt, first_xfer, last_xfer, in_stalls;

    // reference model state: the waveform as the specification describes it
    int unsigned m_exp, m_wid, m_wlen, m_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_exp = 0; m_wid = 0; m_wlen = 0; m_cnt = 0;
    endtask

    // Expected output of one fragment, from the reassembly rules.
    task automatic model_frag(input beat_t f[$]);
        if (f[0].data != CMD) return;
        if (f.size() < HDR_WORDS + 1) return;   // header cut short by tlast
        if (f[2].data == 0) begin
            m_wid = f[1].data; m_wlen = f[3].data; m_cnt = 0; m_exp = 0;
        end else if (ORDER_CHK && (f[2].data != m_exp || f[1].data != m_wid)) begin
            return;
        end
        if (m_wlen == 0 || m_cnt >= m_wlen) return;
        for (int i = HDR_WORDS; i < f.size(); i++) begin
            exp_q.push_back({f[i].data, f[i].keep, f[i].dest, f[i].id, f[i].user,
                             (m_cnt + 1 == m_wlen)});
            m_cnt++;
            if (m_cnt == m_wlen) begin
                m_exp = 0;
                return;
            end
        end
        m_exp++;
    endtask

    task automatic send_frag(input logic [31:0] cmd, input logic [31:0] fid,
                             input logic [31:0] ind, input logic [31:0] len,
                             input int ndata, input bit seq_data, input int trunc_at);
        beat_t f[$];
        beat_t b;
        logic [31:0] hdr [5];
        hdr = '{cmd, fid, ind, len, $urandom};
        for (int i = 0; i < HDR_WORDS + ndata; i++) begin
            if (i < HDR_WORDS) b.data = hdr[i];
            else               b.data = seq_data ? 32'(5 + i - HDR_WORDS) : $urandom;
            b.keep = 4'($urandom);
            b.dest = 1'($urandom);
            b.id   = 1'($urandom);
            b.user = 1'($urandom);
            b.last = (i == HDR_WORDS + ndata - 1) || (i == trunc_at);
            f.push_back(b);
            if (b.last) break;
        end
        foreach (f[i]) in_q.push_back(f[i]);
        model_frag(f);
    endtask

    task automatic clear_stats();
        xfer_cnt = 0; first_xfer = 0; last_xfer = 0; in_stalls = 0;
    endtask

    // One clock cycle: sample at negedge, advance/drive just after posedge.
    task automatic step();
        bit in_fire;
        @(negedge axi_tclk);
        if (prev_stall)
            check("hold_stable", {23'd0, tvalid, out_vec}, {23'd0, 1'b1, held_vec});
        prev_stall = tvalid && !tready;
        held_vec   = out_vec;
        if (tvalid && tready) begin
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_out: observed word %h, required no output", out_vec);
            end
            if (exp_q.size() != 0) check("out_word", 64'(out_vec), 64'(exp_q.pop_front()));
            if (xfer_cnt == 0) first_xfer = cyc;
            last_xfer = cyc;
            xfer_cnt++;
        end
        in_fire = wfrm_axis_tvalid && wfrm_axis_tready;
        if (wfrm_axis_tvalid && !wfrm_axis_tready) in_stalls++;
        @(posedge axi_tclk);
        #1;
        cyc++;
        if (in_fire) void'(in_q.pop_front());
        if (in_q.size() != 0 &&
            ((wfrm_axis_tvalid && !in_fire) || !rand_valid || $urandom_range(3) != 0)) begin
            wfrm_axis_tvalid = 1'b1;
            wfrm_axis_tdata  = in_q[0].data;
            wfrm_axis_tlast  = in_q[0].last;
            wfrm_axis_tkeep  = in_q[0].keep;
            wfrm_axis_tdest  = in_q[0].dest;
            wfrm_axis_tid    = in_q[0].id;
            wfrm_axis_tuser  = in_q[0].user;
        end else begin
            wfrm_axis_tvalid = 1'b0;
        end
        case (tready_mode)
            0:       tready = 1'b1;
            1:       tready = ~tready;
            default: tready = 1'($urandom_range(1));
        endcase
    endtask

    task automatic run_to_idle(input string tag, input int budget);
        int start;
        start = cyc;
        while ((in_q.size() != 0 || exp_q.size() != 0) && (cyc - start) < budget) step();
        tests++;
        assert (in_q.size() == 0 && exp_q.size() == 0) else begin
            fails++;
            $error("FAIL %s_timeout: observed %0d inputs and %0d outputs pending, required 0",
                   tag, in_q.size(), exp_q.size());
        end
        repeat (8) step();
    endtask

    initial begin
        model_reset();
        clear_stats();

        // ---- reset state ----
        #2;
        check("rst_tvalid", 64'(tvalid), 64'd0);
        check("rst_tlast", 64'(tlast), 64'd0);
        check("rst_tdata", 64'(tdata), 64'd0);
        check("rst_tkeep", 64'(tkeep), 64'd0);
        check("rst_in_ready", 64'(wfrm_axis_tready), 64'd0);
        repeat (3) @(posedge axi_tclk);
        #1 axi_treset = 1'b0;
        step();
        check("post_rst_tvalid", 64'(tvalid), 64'd0);

        // ---- 4 x 256-word fragments, LEN 1004, tready high ----
        tready_mode = 0; rand_valid = 1'b0; clear_stats();
        for (int k = 0; k < 4; k++) send_frag(CMD, 0, k, 1004, 251, 1'b1, -1);
        run_to_idle("full_wave", 3000);
        check("full_wave_words", xfer_cnt, 1004);
        check("full_wave_gaps", (last_xfer - first_xfer + 1) - xfer_cnt, 15);

        // ---- bad CMD, truncated header, then a normal waveform ----
        clear_stats();
        send_frag(32'h12345678, 0, 0, 20, 251, 1'b0, -1);
        send_frag(CMD, 0, 0, 40, 10, 1'b0, 2);
        send_frag(CMD, 0, 0, 20, 20, 1'b0, -1);
        run_to_idle("bad_cmd", 1500);
        check("bad_cmd_words", xfer_cnt, 20);

        // ---- LEN shorter than the fragment: tail dropped at full rate ----
        clear_stats();
        send_frag(CMD, 0, 0, 100, 251, 1'b0, -1);
        run_to_idle("short_len", 1000);
        check("short_len_words", xfer_cnt, 100);
        check("short_len_in_stalls", in_stalls, 0);

        // ---- tready toggling, bursty input ----
        tready_mode = 1; rand_valid = 1'b1; clear_stats();
        for (int k = 0; k < 4; k++) send_frag(CMD, 0, k, 1004, 251, 1'b0, -1);
        run_to_idle("toggle", 10000);
        check("toggle_words", xfer_cnt, 1004);

        // ---- fragment order / ID handling ----
        tready_mode = 2; clear_stats();
        send_frag(CMD, 3, 0, 30, 10, 1'b0, -1);
        send_frag(CMD, 3, 2, 0, 10, 1'b0, -1);
        send_frag(CMD, 1, 1, 0, 10, 1'b0, -1);
        send_frag(CMD, 3, 1, 0, 10, 1'b0, -1);
        send_frag(CMD, 3, 2, 0, 10, 1'b0, -1);
        run_to_idle("order", 2000);
        check("order_words", xfer_cnt, 30);

        // ---- reset during fragment 1 ----
        tready_mode = 0; rand_valid = 1'b0; clear_stats();
        send_frag(CMD, 0, 0, 600, 251, 1'b0, -1);
        send_frag(CMD, 0, 1, 600, 251, 1'b0, -1);
        repeat (300) step();
        check("pre_rst_tvalid", 64'(tvalid), 64'd1);
        #2 axi_treset = 1'b1;
        #1;
        check("mid_rst_tvalid", 64'(tvalid), 64'd0);
        check("mid_rst_tlast", 64'(tlast), 64'd0);
        check("mid_rst_tdata", 64'(tdata), 64'd0);
        check("mid_rst_in_ready", 64'(wfrm_axis_tready), 64'd0);
        in_q.delete();
        exp_q.delete();
        model_reset();
        wfrm_axis_tvalid = 1'b0;
        prev_stall = 1'b0;
        repeat (2) @(posedge axi_tclk);
        #2 axi_treset = 1'b0;
        tready_mode = 2; rand_valid = 1'b1; clear_stats();
        send_frag(CMD, 0, 0, 50, 25, 1'b0, -1);
        send_frag(CMD, 0, 1, 50, 25, 1'b0, -1);
        run_to_idle("after_rst", 1000);
        check("after_rst_words", xfer_cnt, 50);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/waveform_formatter.md
# waveform_formatter

Reassembles fragmented waveform packets arriving on an AXI4-Stream input into one contiguous waveform stream. Each fragment carries a 5-word header (command, waveform ID, fragment index, total waveform length, reserved) followed by data words. The block validates and strips the header, forwards the data words, and asserts `tlast` only on the final word of the complete waveform. It sits between the waveform source FIFO and the downstream waveform consumer (DAC/BRAM path), in a single clock domain.

## Interface
Parameters:
- `WFRM_CMD`, default 32'h57574441 ("WWDA"): required value of header word 0.
- `DEST_W`, default 1: `tdest` width.
- `ID_W`, default 1: `tid` width.
- `USER_W`, default 1: `tuser` width.

Ports:
- One clock; reset is asynchronous and active-high.
- `axi_tclk` in 1: clock.
- `axi_treset` in 1: asynchronous, active-high reset.
- `wfrm_axis_tdata` in 32: input fragment data.
- `wfrm_axis_tvalid` in 1: input valid.
- `wfrm_axis_tlast` in 1: last word of the fragment.
- `wfrm_axis_tkeep` in 4: byte keep, forwarded on data words.
- `wfrm_axis_tdest` in DEST_W, `wfrm_axis_tid` in ID_W, `wfrm_axis_tuser` in USER_W: forwarded on data words.
- `wfrm_axis_tready` out 1: input ready.
- `tdata` out 32, `tvalid` out 1, `tlast` out 1, `tkeep` out 4, `tdest` out DEST_W, `tid` out ID_W, `tuser` out USER_W: output stream.
- `tready` in 1: output ready.

## Operation
- An input word is accepted when `wfrm_axis_tvalid & wfrm_axis_tready`. An output word transfers when `tvalid & tready`.
- Header words, in order: word 0 is CMD, word 1 is ID, word 2 is IND (fragment index), word 3 is LEN (total waveform data words), word 4 is reserved.
- FSM states: H_CMD (reset state), H_ID, H_IND, H_LEN, H_RSVD, DATA, DROP.
- In H_* states, `wfrm_axis_tready`=1. Each accepted word advances the FSM; nothing is output.
- H_CMD: if the word differs from WFRM_CMD, go to DROP.
- H_IND: if IND==0, start a new waveform. Latch ID and LEN in H_LEN, and clear `out_cnt` to 0. If IND!=0 and it fails the order check (see Configuration), the fragment goes to DROP after the header.
- After H_RSVD, go to DATA. If LEN==0, go to DROP instead.
- DATA: each accepted word is output with its tkeep/tdest/tid/tuser, and `out_cnt` increments (32 bits). `tlast` is set on the word where `out_cnt+1==LEN`. After that word, the expected index returns to 0 and the rest of the fragment is dropped.
- DATA: an input tlast before LEN is reached returns the FSM to H_CMD and increments the expected index.
- DROP: `wfrm_axis_tready`=1. Words are discarded until input tlast, then the FSM returns to H_CMD.
- An input tlast inside the header returns the FSM to H_CMD with no output.
- An IND==0 fragment arriving mid-waveform restarts the waveform. The truncated waveform is never terminated with tlast.

## Timing
- The output is a one-entry pipeline register, so latency is 1 cycle from input acceptance.
- DATA: `wfrm_axis_tready = ~tvalid | tready`. This gives full throughput with `tready` held high.
- Output valid must not drop, and its payload must not change, until the word transfers.
- Each fragment costs 5 header cycles with no output.
- Reset clears the FSM to H_CMD, `tvalid`=0, `tlast`=0, tdata/tkeep/tdest/tid/tuser=0, `out_cnt`=0, expected index=0, and `wfrm_axis_tready`=0.
- Reset mid-waveform discards all state, including any held output word.

## Configuration
- `WAVEFORM_FORMATTER_ORDER_CHECK_EN` defined: a fragment with IND!=0 is accepted only if IND equals the expected index and ID equals the latched ID. Otherwise it is dropped, and the expected state is unchanged.
- Undefined: any fragment with a valid CMD is forwarded, regardless of IND/ID. IND==0 still restarts `out_cnt`, and LEN still governs tlast.

## Structure
- `waveform_formatter_pkg` holds the WFRM_CMD default, the header word offsets (0–4), the header length constant 5, and the FSM state enum.
- One sub-module, `axis_out_reg`: the one-entry AXI-Stream output register with ready/valid.

## Test plan
- 4 fragments of 256 words each (5 header + 251 data words of value 5..255), CMD=0x57574441, ID=0, IND=0..3, LEN=1004, `tready`=1 -> 1004 output words with no gaps, tlast only on word 1004, 20 header cycles of no output.
- Fragment whose CMD is 0x12345678 -> entire fragment consumed, no output, next valid fragment processed normally.
- Single fragment with LEN=100 and 251 data words -> 100 output words, tlast on the 100th, remaining 151 words dropped with `wfrm_axis_tready`=1.
- `tready` toggled 1/0 every cycle -> identical output sequence, no lost or duplicated word, payload stable while stalled.
- With the macro: IND sequence 0, 2 -> fragment 2 dropped; a following IND=1 is accepted. Without the macro: the IND=2 data is forwarded.
- Reset asserted during fragment 1 -> `tvalid`=0 immediately; after release, an IND=0 waveform is reassembled correctly.
